dlx_mem_arbiter: RTL

- Parametrised memory front-end that merges N_PORTS independent DLX-style memory requesters onto one shared memory port. Requesters are IRAM fetch, DRAM load/store and additional cores or a debug loader.
- Sits between the core memory interfaces and a single unified memory model or controller.
- Adds two things a direct port-to-memory connection does not have: selectable arbitration (round-robin or fixed priority) and a per-transaction timeout with an error response.

---
 rtl/dlx_mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter: merges N_PORTS DLX-style requesters onto one shared memory
// port with round-robin or fixed-priority arbitration and a per-transaction
// timeout that completes the access with an error response.
module dlx_mem_arbiter #(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned GID_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req_enable,
  input  logic [N_PORTS-1:0]         req_rnw,
  input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
  input  logic [N_PORTS*DATA_W-1:0]  req_wdata,
  output logic [N_PORTS-1:0]         rsp_ready,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_enable,
  output logic                       mem_rnw,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic [GID_W-1:0]           grant_id,
  output logic                       busy
);

  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [GID_W-1:0]     last_grant_q, last_grant_d;
  logic [GID_W-1:0]     grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mem_enable_q, mem_enable_d;
  logic                 mem_rnw_q, mem_rnw_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [N_PORTS-1:0]   rsp_ready_q, rsp_ready_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 busy_q, busy_d;
  logic [GID_W-1:0]     win_c;
  logic                 timeout_hit_c;

  // Winner search; later loop iterations have higher precedence, so each loop
  // walks the search order backwards and the first candidate overwrites last.
  function automatic logic [GID_W-1:0] pick_winner(input logic [N_PORTS-1:0] req,
                                                   input logic [GID_W-1:0]   last);
    logic [GID_W-1:0] w;
    logic [GID_W-1:0] idx;
    w = '0;
    if (PRIO_MODE == 1) begin
      for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
        if (req[GID_W'(i)]) w = GID_W'(i);
      end
    end else begin
      for (int unsigned i = N_PORTS; i >= 1; i--) begin
        idx = GID_W'((32'(last) + i) % N_PORTS);
        if (req[idx]) w = idx;
      end
    end
    return w;
  endfunction

  // Arbitration result and timeout detection for the current cycle.
  always_comb begin
    win_c         = pick_winner(req_enable, last_grant_q);
    timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    mem_enable_d = mem_enable_q;
    mem_rnw_d    = mem_rnw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rsp_ready_d  = '0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_enable) begin
          grant_d      = win_c;
          if (PRIO_MODE == 0) last_grant_d = win_c;
          mem_enable_d = 1'b1;
          mem_rnw_d    = req_rnw[win_c];
          mem_addr_d   = req_addr[win_c*ADDR_W +: ADDR_W];
          mem_wdata_d  = req_wdata[win_c*DATA_W +: DATA_W];
          cnt_d        = '0;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          rsp_ready_d  = N_PORTS'(1) << grant_q;
          rsp_rdata_d  = mem_rdata;
          mem_enable_d = 1'b0;
          state_d      = ST_DONE;
        end else if (timeout_hit_c) begin
          rsp_ready_d  = N_PORTS'(1) << grant_q;
          rsp_err_d    = 1'b1;
          rsp_rdata_d  = '0;
          mem_enable_d = 1'b0;
          state_d      = ST_DONE;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any in-flight access silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GID_W'(N_PORTS - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      mem_enable_q <= 1'b0;
      mem_rnw_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_ready_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      mem_enable_q <= mem_enable_d;
      mem_rnw_q    <= mem_rnw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp_ready_q  <= rsp_ready_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_ready  = rsp_ready_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign mem_enable = mem_enable_q;
  assign mem_rnw    = mem_rnw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;

endmodule
